ram_sync_dp: RTL and testbench



---
 rtl/ram_pkg.sv | 25 ++
 rtl/ram_pipe.sv | 79 +++++++
 rtl/ram_sync_dp.sv | 180 ++++++++++++++++++
 tb/tb_ram_sync_dp.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared definitions for the synchronous dual-port operand RAM:
// controller state encoding, read-during-write mode constants and the
// read-latency legality check used at elaboration time.
package ram_pkg;

    // Controller states: zeroing the array after reset, or serving requests.
    typedef enum logic {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } state_e;

    // Read-during-write behaviour when the other port writes the same word.
    localparam int unsigned RD_FIRST = 0;  // reader sees the pre-write word
    localparam int unsigned WR_FIRST = 1;  // reader sees the word being written

    // Supported read latency range, in clock cycles.
    localparam int unsigned LAT_MIN = 1;
    localparam int unsigned LAT_MAX = 3;

    // True when a requested read latency can be built by the read pipeline.
    function automatic bit lat_legal(input int unsigned lat);
        return (lat >= LAT_MIN) && (lat <= LAT_MAX);
    endfunction

endpackage

// File: rtl/ram_pipe.sv
// Read-result delay line for one RAM port. Carries {valid, data} through
// LAT register stages. The last stage is the port's output register: its
// data only changes when a result arrives, so the read word stays on the
// output until the next read completes. Reset flushes every valid bit and
// zeroes the visible output word; intermediate data stages carry no reset
// because their contents are ignored while their valid bit is low.
module ram_pipe
    import ram_pkg::*;
#(
    parameter int unsigned DATA = 198,
    parameter int unsigned LAT  = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            valid_i,
    input  logic [DATA-1:0] data_i,
    output logic            valid_o,
    output logic [DATA-1:0] data_o
);

    // Signals entering the output register, after LAT-1 delay stages.
    logic            head_valid;
    logic [DATA-1:0] head_data;

    // Output register.
    logic            valid_q;
    logic [DATA-1:0] data_q;

    if (LAT > 1) begin : g_stages
        logic [LAT-2:0]            stage_valid_q;
        logic [LAT-2:0][DATA-1:0]  stage_data_q;
        logic [LAT-1:0]            valid_shift;
        logic [LAT-1:0][DATA-1:0]  data_shift;

        // New entries enter at index 0; the oldest sits at the top index.
        assign valid_shift = {stage_valid_q, valid_i};
        assign data_shift  = {stage_data_q, data_i};

        // Shift the valid bits; reset drops every read still in flight.
        // NOTE: non-blocking assignments make all stages update from the
        // pre-edge values, so entries advance one stage per clock instead
        // of rippling through the whole chain in a single cycle.
        always_ff @(posedge clk) begin
            if (reset) begin
                stage_valid_q <= '0;
            end else begin
                stage_valid_q <= valid_shift[LAT-2:0];
            end
        end

        // Shift the data words alongside their valid bits (no reset needed).
        always_ff @(posedge clk) begin
            stage_data_q <= data_shift[LAT-2:0];
        end

        assign head_valid = stage_valid_q[LAT-2];
        assign head_data  = stage_data_q[LAT-2];
    end else begin : g_direct
        assign head_valid = valid_i;
        assign head_data  = data_i;
    end

    // Output register: pulse valid for one cycle, hold data between reads.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= head_valid;
            if (head_valid) begin
                data_q <= head_data;
            end
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/ram_sync_dp.sv
// Synchronous dual-port RAM used as the operand store shared by the pairing
// controller and the arithmetic units. Both ports read or write one word per
// cycle. After reset an optional sequencer writes zero to every address, one
// per cycle, while busy is high and requests are ignored. Reads are returned
// LAT cycles after acceptance with a one-cycle valid strobe. When both ports
// write the same word in one cycle port A wins and port B is told through a
// one-cycle b_coll pulse. A read racing a write from the other port to the
// same word returns either the old word or the new one, chosen by WMODE.
module ram_sync_dp
    import ram_pkg::*;
#(
    parameter int unsigned DATA  = 198,
    parameter int unsigned ADDR  = 6,
    parameter int unsigned LAT   = 1,
    parameter int unsigned WMODE = RD_FIRST,
    parameter bit          CLEAR = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    output logic            busy,

    input  logic            a_req,
    input  logic            a_wr,
    input  logic [ADDR-1:0] a_addr,
    input  logic [DATA-1:0] a_din,
    output logic [DATA-1:0] a_dout,
    output logic            a_valid,
    output logic            a_coll,

    input  logic            b_req,
    input  logic            b_wr,
    input  logic [ADDR-1:0] b_addr,
    input  logic [DATA-1:0] b_din,
    output logic [DATA-1:0] b_dout,
    output logic            b_valid,
    output logic            b_coll
);

    localparam int unsigned DEPTH = 2 ** ADDR;

    if (!lat_legal(LAT)) begin : g_lat_check
        $error("ram_sync_dp: LAT must be within 1..3");
    end

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    // NOTE: the array has no reset branch. Resetting every word would turn
    // the RAM into a huge flop bank; zeroing is the clear sequencer's job.
    logic [DATA-1:0] mem_q [DEPTH];

    // ------------------------------------------------------------------
    // Controller: clear sequencer and busy flag
    // ------------------------------------------------------------------
    state_e          state_q;
    logic [ADDR-1:0] clr_q;
    logic            busy_q;
    logic            b_coll_q;

    // Walk the clear counter over every address, then hand over to S_RUN.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= CLEAR ? S_CLEAR : S_RUN;
            busy_q  <= CLEAR;
            clr_q   <= '0;
        end else begin
            case (state_q)
                S_CLEAR: begin
                    clr_q <= clr_q + 1'b1;
                    if (clr_q == '1) begin
                        state_q <= S_RUN;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_RUN;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Request decode, collision and bypass
    // ------------------------------------------------------------------
    logic            run;
    logic            a_rd_acc;
    logic            a_wr_acc;
    logic            b_rd_acc;
    logic            b_wr_acc;
    logic            wr_coll;
    logic            b_wr_eff;
    logic [DATA-1:0] a_rd_d;
    logic [DATA-1:0] b_rd_d;

    assign run = (state_q == S_RUN);

    // Classify each port's access; requests count only while running.
    always_comb begin
        a_rd_acc = run && a_req && !a_wr;
        a_wr_acc = run && a_req && a_wr;
        b_rd_acc = run && b_req && !b_wr;
        b_wr_acc = run && b_req && b_wr;
        // Port A has priority on a same-word double write.
        wr_coll  = a_wr_acc && b_wr_acc && (a_addr == b_addr);
        b_wr_eff = b_wr_acc && !wr_coll;
    end

    // Select the word each reader captures this cycle.
    // NOTE: every output of this block gets a default before any condition,
    // so no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        a_rd_d = mem_q[a_addr];
        b_rd_d = mem_q[b_addr];
        if (WMODE == WR_FIRST) begin
            if (b_wr_eff && (b_addr == a_addr)) begin
                a_rd_d = b_din;
            end
            if (a_wr_acc && (a_addr == b_addr)) begin
                b_rd_d = a_din;
            end
        end
    end

    // Commit writes: zeros while clearing, otherwise both ports' writes.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state_q == S_CLEAR) begin
                mem_q[clr_q] <= '0;
            end else begin
                if (a_wr_acc) begin
                    mem_q[a_addr] <= a_din;
                end
                if (b_wr_eff) begin
                    mem_q[b_addr] <= b_din;
                end
            end
        end
    end

    // Flag port B's dropped write for one cycle after the collision.
    always_ff @(posedge clk) begin
        if (reset) begin
            b_coll_q <= 1'b0;
        end else begin
            b_coll_q <= wr_coll;
        end
    end

    // ------------------------------------------------------------------
    // Read result pipelines
    // ------------------------------------------------------------------
    ram_pipe #(
        .DATA (DATA),
        .LAT  (LAT)
    ) u_pipe_a (
        .clk     (clk),
        .reset   (reset),
        .valid_i (a_rd_acc),
        .data_i  (a_rd_d),
        .valid_o (a_valid),
        .data_o  (a_dout)
    );

    ram_pipe #(
        .DATA (DATA),
        .LAT  (LAT)
    ) u_pipe_b (
        .clk     (clk),
        .reset   (reset),
        .valid_i (b_rd_acc),
        .data_i  (b_rd_d),
        .valid_o (b_valid),
        .data_o  (b_dout)
    );

    assign busy   = busy_q;
    assign a_coll = 1'b0;
    assign b_coll = b_coll_q;

endmodule

// File: tb/tb_ram_sync_dp.sv
// Self-checking bench for ram_sync_dp. Three instances share one stimulus
// stream and differ in configuration:
//   inst0: LAT=1, read-first,  clear on reset
//   inst1: LAT=2, write-first, clear on reset
//   inst2: LAT=3, read-first,  no clear
// Each instance has a behavioural model (word array plus a queue of pending
// read results with due times) compared against the DUT on every cycle,
// and directed phases pin the model with literal expectations.
module tb_ram_sync_dp;

    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int NI    = 3;

    function automatic int cfg_lat(input int i);
        return (i == 0) ? 1 : (i == 1) ? 2 : 3;
    endfunction

    function automatic int cfg_wm(input int i);
        return (i == 1) ? 1 : 0;
    endfunction

    function automatic bit cfg_clr(input int i);
        return (i != 2);
    endfunction

    logic          clk   = 1'b0;
    logic          reset = 1'b1;
    logic          a_req = 1'b0, a_wr = 1'b0, b_req = 1'b0, b_wr = 1'b0;
    logic [AW-1:0] a_addr = '0, b_addr = '0;
    logic [DW-1:0] a_din = '0, b_din = '0;

    bit chk_en = 1'b0;
    int n_cmp  = 0;
    int n_mis  = 0;

    logic          busy_w    [NI];
    logic          a_valid_w [NI];
    logic          b_valid_w [NI];
    logic          a_coll_w  [NI];
    logic          b_coll_w  [NI];
    logic [DW-1:0] a_dout_w  [NI];
    logic [DW-1:0] b_dout_w  [NI];
    logic [DW-1:0] m_bd_w    [NI];

    int bcnt [NI];
    int vcnt [NI];

    always #5 clk = ~clk;

    task automatic check(input string name, input int inst,
                         input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s inst%0d: got %0h expected %0h (t=%0t)",
                     name, inst, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // DUT instances and their reference models
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NI; gi++) begin : g
        localparam int unsigned L  = cfg_lat(gi);
        localparam int unsigned WM = cfg_wm(gi);
        localparam bit          CL = cfg_clr(gi);

        ram_sync_dp #(
            .DATA  (DW),
            .ADDR  (AW),
            .LAT   (L),
            .WMODE (WM),
            .CLEAR (CL)
        ) dut (
            .clk     (clk),
            .reset   (reset),
            .busy    (busy_w[gi]),
            .a_req   (a_req),
            .a_wr    (a_wr),
            .a_addr  (a_addr),
            .a_din   (a_din),
            .a_dout  (a_dout_w[gi]),
            .a_valid (a_valid_w[gi]),
            .a_coll  (a_coll_w[gi]),
            .b_req   (b_req),
            .b_wr    (b_wr),
            .b_addr  (b_addr),
            .b_din   (b_din),
            .b_dout  (b_dout_w[gi]),
            .b_valid (b_valid_w[gi]),
            .b_coll  (b_coll_w[gi])
        );

        typedef struct {
            int            due;
            bit            port_b;
            logic [DW-1:0] data;
            bit            known;
        } rd_t;

        rd_t           pend [$];
        logic [DW-1:0] m_mem   [DEPTH];
        bit            m_known [DEPTH];
        int            clr_left = 0;
        int            mcyc     = 0;
        bit            e_busy = 1'b0, e_av = 1'b0, e_bv = 1'b0, e_bc = 1'b0;
        bit            e_ak = 1'b1, e_bk = 1'b1;
        logic [DW-1:0] e_ad = '0, e_bd = '0;

        assign m_bd_w[gi] = e_bd;

        // Reference behaviour, advanced once per rising edge.
        always @(posedge clk) begin : model_step
            logic [DW-1:0] d;
            bit            k;
            mcyc++;
            e_av = 1'b0;
            e_bv = 1'b0;
            e_bc = 1'b0;
            if (reset) begin
                pend.delete();
                clr_left = CL ? DEPTH : 0;
                e_ad = '0;
                e_bd = '0;
                e_ak = 1'b1;
                e_bk = 1'b1;
            end else if (clr_left > 0) begin
                m_mem[DEPTH - clr_left]   = '0;
                m_known[DEPTH - clr_left] = 1'b1;
                clr_left--;
            end else begin
                if (a_req && !a_wr) begin
                    d = m_mem[a_addr];
                    k = m_known[a_addr];
                    if (WM == 1 && b_req && b_wr && b_addr == a_addr) begin
                        d = b_din;
                        k = 1'b1;
                    end
                    pend.push_back('{due: mcyc + int'(L) - 1, port_b: 1'b0, data: d, known: k});
                end
                if (b_req && !b_wr) begin
                    d = m_mem[b_addr];
                    k = m_known[b_addr];
                    if (WM == 1 && a_req && a_wr && a_addr == b_addr) begin
                        d = a_din;
                        k = 1'b1;
                    end
                    pend.push_back('{due: mcyc + int'(L) - 1, port_b: 1'b1, data: d, known: k});
                end
                if (a_req && a_wr) begin
                    m_mem[a_addr]   = a_din;
                    m_known[a_addr] = 1'b1;
                end
                if (b_req && b_wr) begin
                    if (a_req && a_wr && a_addr == b_addr) begin
                        e_bc = 1'b1;
                    end else begin
                        m_mem[b_addr]   = b_din;
                        m_known[b_addr] = 1'b1;
                    end
                end
            end
            while (pend.size() > 0 && pend[0].due == mcyc) begin
                if (pend[0].port_b) begin
                    e_bv = 1'b1;
                    e_bd = pend[0].data;
                    e_bk = pend[0].known;
                end else begin
                    e_av = 1'b1;
                    e_ad = pend[0].data;
                    e_ak = pend[0].known;
                end
                void'(pend.pop_front());
            end
            e_busy = (clr_left > 0);
        end

        // Compare every output against the model away from the active edge.
        always @(negedge clk) begin
            if (chk_en) begin
                check("busy",    gi, 64'(busy_w[gi]),    64'(e_busy));
                check("a_valid", gi, 64'(a_valid_w[gi]), 64'(e_av));
                check("b_valid", gi, 64'(b_valid_w[gi]), 64'(e_bv));
                check("a_coll",  gi, 64'(a_coll_w[gi]),  64'(1'b0));
                check("b_coll",  gi, 64'(b_coll_w[gi]),  64'(e_bc));
                if (e_ak) check("a_dout", gi, 64'(a_dout_w[gi]), 64'(e_ad));
                if (e_bk) check("b_dout", gi, 64'(b_dout_w[gi]), 64'(e_bd));
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (all driven just after the falling edge)
    // ------------------------------------------------------------------
    task automatic idle();
        a_req = 1'b0;
        a_wr  = 1'b0;
        b_req = 1'b0;
        b_wr  = 1'b0;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic drive_random();
        a_req  = ($urandom_range(0, 9) < 8);
        a_wr   = 1'($urandom_range(0, 1));
        a_addr = AW'($urandom_range(0, DEPTH - 1));
        a_din  = $urandom;
        b_req  = ($urandom_range(0, 9) < 8);
        b_wr   = 1'($urandom_range(0, 1));
        b_addr = AW'($urandom_range(0, DEPTH - 1));
        b_din  = $urandom;
    endtask

    task automatic wr_a(input int addr, input logic [DW-1:0] data);
        a_req = 1'b1; a_wr = 1'b1; a_addr = AW'(addr); a_din = data;
    endtask

    task automatic rd_a(input int addr);
        a_req = 1'b1; a_wr = 1'b0; a_addr = AW'(addr);
    endtask

    task automatic wr_b(input int addr, input logic [DW-1:0] data);
        b_req = 1'b1; b_wr = 1'b1; b_addr = AW'(addr); b_din = data;
    endtask

    task automatic rd_b(input int addr);
        b_req = 1'b1; b_wr = 1'b0; b_addr = AW'(addr);
    endtask

    // One-cycle reset pulse, then count busy and valid samples over the
    // following 22 cycles. mode 0: idle; 1: port B reads address 3 in the
    // first cycle after reset; 2: random requests for the first 16 cycles.
    task automatic reset_window(input int mode);
        idle();
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < NI; i++) begin
            bcnt[i] = 0;
            vcnt[i] = 0;
        end
        for (int k = 0; k < 22; k++) begin
            for (int i = 0; i < NI; i++) begin
                if (busy_w[i]) bcnt[i]++;
                if (a_valid_w[i] || b_valid_w[i]) vcnt[i]++;
            end
            idle();
            if (mode == 1 && k == 0) rd_b(3);
            if (mode == 2 && k < 16) drive_random();
            step();
        end
        idle();
    endtask

    // ------------------------------------------------------------------
    // Directed phases followed by a randomized run
    // ------------------------------------------------------------------
    initial begin : main
        int lat_seen [NI];

        step();
        chk_en = 1'b1;
        for (int i = 0; i < NI; i++) begin
            check("rst_busy",  i, 64'(busy_w[i]),   64'(cfg_clr(i)));
            check("rst_adout", i, 64'(a_dout_w[i]), 64'(0));
            check("rst_bdout", i, 64'(b_dout_w[i]), 64'(0));
        end

        // Initial clear with requests hammering the ports while busy.
        reset_window(2);
        for (int i = 0; i < NI; i++) begin
            check("clr_busy_len", i, 64'(bcnt[i]), 64'(cfg_clr(i) ? 16 : 0));
            if (cfg_clr(i)) check("clr_no_valid", i, 64'(vcnt[i]), 64'(0));
        end

        // Preload every word with a nonzero pattern.
        for (int j = 0; j < 8; j++) begin
            wr_a(j, 32'hC0DE_0000 + DW'(j));
            wr_b(j + 8, 32'hC0DE_0000 + DW'(j + 8));
            step();
        end
        idle();
        repeat (4) step();

        // Reset again; the no-clear instance keeps and returns old content.
        reset_window(1);
        for (int i = 0; i < NI; i++) begin
            check("clr2_busy_len", i, 64'(bcnt[i]), 64'(cfg_clr(i) ? 16 : 0));
            check("clr2_valids",   i, 64'(vcnt[i]), 64'(cfg_clr(i) ? 0 : 1));
            check("clr2_bdout",    i, 64'(b_dout_w[i]),
                  64'(cfg_clr(i) ? 32'h0 : 32'hC0DE_0003));
            check("clr2_model",    i, 64'(m_bd_w[i]),
                  64'(cfg_clr(i) ? 32'h0 : 32'hC0DE_0003));
        end

        // Back-to-back reads of every address.
        for (int j = 0; j < DEPTH; j++) begin
            rd_a(j);
            step();
        end
        idle();
        repeat (4) step();
        for (int i = 0; i < NI; i++) begin
            check("sweep_last", i, 64'(a_dout_w[i]),
                  64'(cfg_clr(i) ? 32'h0 : 32'hC0DE_000F));
        end

        // Latency: write via A, read via B next cycle, measure arrival.
        wr_a(3, 32'h5A);
        step();
        idle();
        rd_b(3);
        step();
        idle();
        for (int i = 0; i < NI; i++) lat_seen[i] = -1;
        for (int k = 1; k <= 6; k++) begin
            for (int i = 0; i < NI; i++) begin
                if (b_valid_w[i] && lat_seen[i] < 0) lat_seen[i] = k;
            end
            step();
        end
        for (int i = 0; i < NI; i++) begin
            check("lat_cycles", i, 64'(lat_seen[i]), 64'(cfg_lat(i)));
            check("lat_data",   i, 64'(b_dout_w[i]), 64'(32'h5A));
            check("lat_model",  i, 64'(m_bd_w[i]),   64'(32'h5A));
        end

        // Read-during-write across ports.
        wr_a(9, 32'h11);
        step();
        idle();
        wr_a(9, 32'h22);
        rd_b(9);
        step();
        idle();
        repeat (4) step();
        for (int i = 0; i < NI; i++) begin
            check("rdw_data",  i, 64'(b_dout_w[i]), 64'(cfg_wm(i) ? 32'h22 : 32'h11));
            check("rdw_model", i, 64'(m_bd_w[i]),   64'(cfg_wm(i) ? 32'h22 : 32'h11));
        end
        rd_b(9);
        step();
        idle();
        repeat (4) step();
        for (int i = 0; i < NI; i++) begin
            check("rdw_after", i, 64'(b_dout_w[i]), 64'(32'h22));
        end

        // Double write to the same word.
        wr_a(5, 32'hAA);
        wr_b(5, 32'hBB);
        step();
        idle();
        for (int i = 0; i < NI; i++) begin
            check("coll_b_pulse", i, 64'(b_coll_w[i]), 64'(1));
            check("coll_a_quiet", i, 64'(a_coll_w[i]), 64'(0));
        end
        step();
        for (int i = 0; i < NI; i++) begin
            check("coll_b_end", i, 64'(b_coll_w[i]), 64'(0));
        end
        rd_a(5);
        step();
        idle();
        repeat (4) step();
        for (int i = 0; i < NI; i++) begin
            check("coll_winner", i, 64'(a_dout_w[i]), 64'(32'hAA));
        end

        // Reset one cycle after issuing reads: nothing may come out.
        rd_a(1);
        rd_b(2);
        step();
        reset_window(0);
        for (int i = 0; i < NI; i++) begin
            check("midrst_valids", i, 64'(vcnt[i]), 64'(0));
            check("midrst_busy",   i, 64'(bcnt[i]), 64'(cfg_clr(i) ? 16 : 0));
            check("midrst_adout",  i, 64'(a_dout_w[i]), 64'(0));
            check("midrst_bdout",  i, 64'(b_dout_w[i]), 64'(0));
        end

        // Randomized traffic with occasional reset pulses.
        for (int c = 0; c < 2500; c++) begin
            if ($urandom_range(0, 299) == 0) begin
                idle();
                reset = 1'b1;
                step();
                reset = 1'b0;
            end else begin
                drive_random();
                step();
            end
        end
        idle();
        repeat (6) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
